// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store lane alignment with a 2-entry in-order write queue
module store_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic              busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [31:0]       head_wdata_q, head_wdata_d;
    logic [3:0]        head_be_q, head_be_d;
    logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
    logic [31:0]       tail_wdata_q, tail_wdata_d;
    logic [3:0]        tail_be_q, tail_be_d;
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] new_addr;
    logic [31:0]       new_wdata;
    logic [3:0]        new_be;

    // Handshake outputs depend only on registered state, never on mem_ready/req_valid.
    assign req_ready = (state_q != FULL);
    assign mem_valid = (state_q != EMPTY);
    assign busy      = mem_valid;
    assign mem_addr  = head_addr_q;
    assign mem_wdata = head_wdata_q;
    assign mem_be    = head_be_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

    assign accept   = req_valid && req_ready;
    assign push     = accept && legal;
    assign pop      = mem_valid && mem_ready;
    assign new_addr = {req_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        legal     = 1'b0;
        new_be    = 4'b0000;
        new_wdata = req_data;
        case (req_size)
            2'b00: begin
                legal     = 1'b1;
                new_be    = 4'b0001 << req_addr[1:0];
                new_wdata = {4{req_data[7:0]}};
            end
            2'b01: begin
                legal     = !req_addr[0];
                new_be    = 4'b0011 << {req_addr[1], 1'b0};
                new_wdata = {2{req_data[15:0]}};
            end
            2'b10: begin
                legal     = (req_addr[1:0] == 2'b00);
                new_be    = 4'b1111;
                new_wdata = req_data;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        head_addr_d  = head_addr_q;
        head_wdata_d = head_wdata_q;
        head_be_d    = head_be_q;
        tail_addr_d  = tail_addr_q;
        tail_wdata_d = tail_wdata_q;
        tail_be_d    = tail_be_q;
        err_valid_d  = accept && !legal;
        err_addr_d   = err_addr_q;

        if (accept && !legal) begin
            err_addr_d = req_addr;
        end

        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d      = ONE;
                    head_addr_d  = new_addr;
                    head_wdata_d = new_wdata;
                    head_be_d    = new_be;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_addr_d  = new_addr;
                    head_wdata_d = new_wdata;
                    head_be_d    = new_be;
                end else if (push) begin
                    state_d      = FULL;
                    tail_addr_d  = new_addr;
                    tail_wdata_d = new_wdata;
                    tail_be_d    = new_be;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d      = ONE;
                    head_addr_d  = tail_addr_q;
                    head_wdata_d = tail_wdata_q;
                    head_be_d    = tail_be_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            head_addr_q  <= '0;
            head_wdata_q <= '0;
            head_be_q    <= '0;
            tail_addr_q  <= '0;
            tail_wdata_q <= '0;
            tail_be_q    <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            head_addr_q  <= head_addr_d;
            head_wdata_q <= head_wdata_d;
            head_be_q    <= head_be_d;
            tail_addr_q  <= tail_addr_d;
            tail_wdata_q <= tail_wdata_d;
            tail_be_q    <= tail_be_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - scoreboard bench for store_align_unit
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        busy;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] err_q[$];
    int          checks = 0;
    int          errors = 0;

    store_align_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a write completes at the next rising edge when valid&ready are seen here.
    always @(negedge clk) begin
        if (reset && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_wdata", mem_wdata, e.wdata);
                check("wr_be", {28'd0, mem_be}, {28'd0, e.be});
            end
        end
        if (reset && err_valid) begin
            if (err_q.size() == 0) begin
                check("unexpected_err", err_addr, 32'hFFFF_FFFF);
            end else begin
                check("err_addr", err_addr, err_q.pop_front());
            end
        end
    end

    // Called at posedge+1; holds the request until accepted, returns at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input bit legal, input logic [31:0] ea, input logic [31:0] ew,
                        input logic [3:0] eb);
        int n;
        wr_t e;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (legal) begin
            e.addr  = ea;
            e.wdata = ew;
            e.be    = eb;
            exp_q.push_back(e);
        end else begin
            err_q.push_back(a);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #3;
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_valid", {31'd0, err_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        mem_ready = 1'b1;
        send(32'h13, 32'h0000_00A5, 2'b00, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'b1000);
        check("sb_latency_valid", {31'd0, mem_valid}, 32'd1);
        check("sb_mem_addr", mem_addr, 32'h10);
        check("sb_mem_be", {28'd0, mem_be}, 32'h8);
        check("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        wait_idle();

        send(32'h22, 32'h1234_BEEF, 2'b01, 1'b1, 32'h20, 32'hBEEF_BEEF, 4'b1100);
        check("sh_mem_be", {28'd0, mem_be}, 32'hC);
        wait_idle();

        send(32'h06, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 32'h0, 4'b0);
        check("sw_mis_err_valid", {31'd0, err_valid}, 32'd1);
        check("sw_mis_err_addr", err_addr, 32'h06);
        check("sw_mis_no_write", {31'd0, mem_valid}, 32'd0);
        send(32'h40, 32'h0000_0001, 2'b11, 1'b0, 32'h0, 32'h0, 4'b0);
        check("sz11_err_addr", err_addr, 32'h40);
        check("sz11_no_write", {31'd0, mem_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("err_pulse_one_cycle", {31'd0, err_valid}, 32'd0);
        check("err_addr_held", err_addr, 32'h40);

        mem_ready = 1'b0;
        send(32'h0, 32'h1111_1111, 2'b10, 1'b1, 32'h0, 32'h1111_1111, 4'b1111);
        send(32'h4, 32'h2222_2222, 2'b10, 1'b1, 32'h4, 32'h2222_2222, 4'b1111);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        req_data  = 32'h3333_3333;
        req_size  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_req_ready", {31'd0, req_ready}, 32'd0);
            check("full_hold_addr", mem_addr, 32'h0);
            check("full_hold_wdata", mem_wdata, 32'h1111_1111);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        send(32'h8, 32'h3333_3333, 2'b10, 1'b1, 32'h8, 32'h3333_3333, 4'b1111);
        wait_idle();

        send(32'h101, 32'h0000_0077, 2'b00, 1'b1, 32'h100, 32'h7777_7777, 4'b0010);
        send(32'h106, 32'h0000_ABCD, 2'b01, 1'b1, 32'h104, 32'hABCD_ABCD, 4'b1100);
        check("pushpop_valid", {31'd0, mem_valid}, 32'd1);
        check("pushpop_ready", {31'd0, req_ready}, 32'd1);
        check("pushpop_head", mem_addr, 32'h104);
        @(posedge clk);
        #1;
        check("pushpop_one_entry", {31'd0, mem_valid}, 32'd0);

        mem_ready = 1'b0;
        send(32'h200, 32'h4444_4444, 2'b10, 1'b1, 32'h200, 32'h4444_4444, 4'b1111);
        send(32'h204, 32'h5555_5555, 2'b10, 1'b1, 32'h204, 32'h5555_5555, 4'b1111);
        check("full_before_reset", {31'd0, req_ready}, 32'd0);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flushed_no_write", {31'd0, mem_valid}, 32'd0);
        end

        // Release reset with a request already waiting; the first edge must take it.
        reset = 1'b0;
        #1;
        req_valid = 1'b1;
        req_addr  = 32'h31;
        req_data  = 32'h0000_005A;
        req_size  = 2'b00;
        exp_q.push_back('{addr: 32'h30, wdata: 32'h5A5A_5A5A, be: 4'b0010});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("first_edge_accept", {31'd0, mem_valid}, 32'd1);
        check("first_edge_addr", mem_addr, 32'h30);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("err_queue_empty", err_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
